// File: rtl/mtr_ramp.sv
// mtr_ramp: slew-rate limiter and reversal sequencer for the two wheel speed
// commands feeding the motor driver. Each wheel ramps toward its latched target
// by STEP per ramp tick. A change of direction first ramps the wheel to zero and
// then holds it there for DWELL ticks.
// Optional build macro ESTOP_DECEL_EN: estop decelerates by 4*STEP per tick
// instead of forcing zero immediately. Without the macro, estop zeroes at once.
module mtr_ramp #(
    parameter int STEP     = 16,
    parameter int TICK_DIV = 1024,
    parameter int DWELL    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] lft_cmd,
    input  logic signed [11:0] rght_cmd,
    input  logic               cmd_vld,
    input  logic               estop,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               at_target,
    output logic               in_dwell
);

    localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [12:0] STEP_W  = 13'(STEP);
    localparam logic [7:0]        DWELL_W  = 8'(DWELL);
`ifdef ESTOP_DECEL_EN
    localparam logic signed [13:0] DECEL_W = 14'(4 * STEP);
`endif

    typedef enum logic {
        ST_RAMP  = 1'b0,
        ST_DWELL = 1'b1
    } ch_state_t;

    logic [CNT_W-1:0]   cnt_reg;
    logic               tick;
    logic signed [11:0] cmd [2];
    logic signed [11:0] cur [2];
    logic               dwell [2];
    logic               on_target [2];

    // Clamp a 13-bit intermediate back into the 12-bit signed output range.
    function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
        if (v > 13'sd2047) begin
            return 12'sh7FF;
        end else if (v < -13'sd2048) begin
            return 12'sh800;
        end else begin
            return v[11:0];
        end
    endfunction

    assign cmd[0] = lft_cmd;
    assign cmd[1] = rght_cmd;

    // Shared free-running ramp tick divider; estop and cmd_vld do not touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            ch_state_t          state_reg, state_next;
            logic signed [11:0] cur_reg, cur_next;
            logic signed [11:0] tgt_reg;
            logic [7:0]         dwell_reg, dwell_next;
            logic signed [12:0] cur_w, tgt_w, diff, abs_diff;
            logic signed [12:0] inc_w, dec_w, toward_zero;
            logic               reversal;
`ifdef ESTOP_DECEL_EN
            logic signed [13:0] cur_x, inc_x, dec_x, decel_x;
`endif

            // Target latch. A tick in the same cycle still sees the old target.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tgt_reg <= '0;
                end else if (estop) begin
                    tgt_reg <= '0;
                end else if (cmd_vld) begin
                    tgt_reg <= cmd[gi];
                end
            end

            // Widened copies so differences and steps never wrap.
            assign cur_w    = {cur_reg[11], cur_reg};
            assign tgt_w    = {tgt_reg[11], tgt_reg};
            assign diff     = tgt_w - cur_w;
            assign abs_diff = diff[12] ? -diff : diff;
            assign inc_w    = cur_w + STEP_W;
            assign dec_w    = cur_w - STEP_W;
            assign reversal = (cur_reg != 12'sd0) && (tgt_reg != 12'sd0) &&
                              (cur_reg[11] != tgt_reg[11]);
            // One step toward zero, never crossing it.
            assign toward_zero = cur_reg[11] ? ((inc_w > 13'sd0) ? 13'sd0 : inc_w)
                                             : ((dec_w < 13'sd0) ? 13'sd0 : dec_w);
`ifdef ESTOP_DECEL_EN
            assign cur_x   = {{2{cur_reg[11]}}, cur_reg};
            assign inc_x   = cur_x + DECEL_W;
            assign dec_x   = cur_x - DECEL_W;
            assign decel_x = cur_reg[11] ? ((inc_x > 14'sd0) ? 14'sd0 : inc_x)
                                         : ((dec_x < 14'sd0) ? 14'sd0 : dec_x);
`endif

            // Channel state, speed and dwell counter registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= ST_RAMP;
                    cur_reg   <= '0;
                    dwell_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    cur_reg   <= cur_next;
                    dwell_reg <= dwell_next;
                end
            end

            // Next-state logic: estop first, then per-tick ramp / dwell sequencing.
            always_comb begin
                state_next = state_reg;
                cur_next   = cur_reg;
                dwell_next = dwell_reg;
                if (estop) begin
                    state_next = ST_RAMP;
                    dwell_next = '0;
`ifdef ESTOP_DECEL_EN
                    if (tick) begin
                        cur_next = decel_x[11:0];
                    end
`else
                    cur_next   = '0;
`endif
                end else if (tick) begin
                    case (state_reg)
                        ST_RAMP: begin
                            if (reversal) begin
                                cur_next = toward_zero[11:0];
                                if (toward_zero == 13'sd0) begin
                                    state_next = ST_DWELL;
                                    dwell_next = DWELL_W;
                                end
                            end else if (abs_diff <= STEP_W) begin
                                cur_next = tgt_reg;
                            end else if (diff[12]) begin
                                cur_next = sat12(dec_w);
                            end else begin
                                cur_next = sat12(inc_w);
                            end
                        end
                        ST_DWELL: begin
                            cur_next = '0;
                            if (dwell_reg == 8'd1) begin
                                state_next = ST_RAMP;
                                dwell_next = '0;
                            end else begin
                                dwell_next = dwell_reg - 8'd1;
                            end
                        end
                        default: begin
                            state_next = ST_RAMP;
                            cur_next   = '0;
                            dwell_next = '0;
                        end
                    endcase
                end
            end

            assign cur[gi]       = cur_reg;
            assign dwell[gi]     = (state_reg == ST_DWELL);
            assign on_target[gi] = (cur_reg == tgt_reg);
        end
    endgenerate

    assign lft_spd  = cur[0];
    assign rght_spd = cur[1];
`ifdef ESTOP_DECEL_EN
    assign in_dwell = (dwell[0] | dwell[1]) & ~estop;
`else
    assign in_dwell = dwell[0] | dwell[1];
`endif
    assign at_target = on_target[0] & on_target[1] & ~in_dwell;

endmodule

// File: tb/tb_mtr_ramp.sv
// Testbench for mtr_ramp: directed stimulus, an arithmetic reference model of the
// ramp/dwell/estop rules checked every cycle, plus hand-computed literal points.
module tb_mtr_ramp;

    localparam int STEP     = 16;
    localparam int TICK_DIV = 4;
    localparam int DWELL    = 2;

    logic               clk;
    logic               rst_n;
    logic signed [11:0] lft_cmd;
    logic signed [11:0] rght_cmd;
    logic               cmd_vld;
    logic               estop;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               at_target;
    logic               in_dwell;

    int n_checks = 0;
    int n_fail   = 0;

    mtr_ramp #(
        .STEP     (STEP),
        .TICK_DIV (TICK_DIV),
        .DWELL    (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_cmd   (lft_cmd),
        .rght_cmd  (rght_cmd),
        .cmd_vld   (cmd_vld),
        .estop     (estop),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .at_target (at_target),
        .in_dwell  (in_dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (plain integer arithmetic) ----------------
    int m_cur [2];
    int m_tgt [2];
    int m_dwell [2];   // ramp ticks still to be spent at zero
    int m_cnt;
    bit m_tick_seen;
    bit m_valid = 1'b0;

    function automatic int shrink(input int v, input int s);
        if (v > 0) return (v > s) ? v - s : 0;
        if (v < 0) return (-v > s) ? v + s : 0;
        return 0;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin : model
        bit t;
        int c [2];
        c[0] = lft_cmd;
        c[1] = rght_cmd;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cur[i] = 0; m_tgt[i] = 0; m_dwell[i] = 0;
            end
            m_cnt = 0;
            m_tick_seen = 1'b0;
            m_valid = 1'b1;
        end else begin
            t = (m_cnt == TICK_DIV - 1);
            m_cnt = (m_cnt + 1) % TICK_DIV;
            m_tick_seen = t;
            for (int i = 0; i < 2; i++) begin
                if (estop) begin
                    m_tgt[i] = 0;
                    m_dwell[i] = 0;
`ifdef ESTOP_DECEL_EN
                    if (t) m_cur[i] = shrink(m_cur[i], 4 * STEP);
`else
                    m_cur[i] = 0;
`endif
                end else begin
                    if (t) begin
                        if (m_dwell[i] > 0) begin
                            m_dwell[i] = m_dwell[i] - 1;
                        end else if (m_cur[i] != 0 && m_tgt[i] != 0 &&
                                     ((m_cur[i] < 0) != (m_tgt[i] < 0))) begin
                            m_cur[i] = shrink(m_cur[i], STEP);
                            if (m_cur[i] == 0) m_dwell[i] = DWELL;
                        end else if (iabs(m_tgt[i] - m_cur[i]) <= STEP) begin
                            m_cur[i] = m_tgt[i];
                        end else begin
                            m_cur[i] = m_cur[i] + ((m_tgt[i] > m_cur[i]) ? STEP : -STEP);
                        end
                        if (m_cur[i] > 2047) m_cur[i] = 2047;
                        if (m_cur[i] < -2048) m_cur[i] = -2048;
                    end
                    if (cmd_vld) m_tgt[i] = c[i];
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int exp_dwell;
        int exp_at;
        if (m_valid) begin
            exp_dwell = (m_dwell[0] > 0 || m_dwell[1] > 0) ? 1 : 0;
`ifdef ESTOP_DECEL_EN
            if (estop) exp_dwell = 0;
`endif
            exp_at = (m_cur[0] == m_tgt[0] && m_cur[1] == m_tgt[1] && exp_dwell == 0) ? 1 : 0;
            check("model_lft_spd", int'(lft_spd), m_cur[0]);
            check("model_rght_spd", int'(rght_spd), m_cur[1]);
            check("model_in_dwell", int'(in_dwell), exp_dwell);
            check("model_at_target", int'(at_target), exp_at);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_tick_seen && k < TICK_DIV + 2);
        if (!m_tick_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout at %0t: got no tick, expected one within %0d clocks", $time, TICK_DIV + 2);
        end
    endtask

    task automatic send_cmd(input int l, input int r);
        @(posedge clk); #2;
        lft_cmd  = 12'(l);
        rght_cmd = 12'(r);
        cmd_vld  = 1'b1;
        @(posedge clk); #2;
        cmd_vld  = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog at %0t: got no end of test, expected one", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int up_seq [7]  = '{16, 32, 48, 64, 80, 96, 100};
        int rev_seq [8] = '{24, 8, 0, 0, 0, -16, -32, -40};
        int rev_dw [5]  = '{0, 0, 1, 1, 0};
        int mid_seq [5] = '{0, 0, 16, 32, 40};
        int mid_dw [5]  = '{1, 0, 0, 0, 0};

        rst_n = 1'b0; estop = 1'b0; cmd_vld = 1'b0;
        lft_cmd = '0; rght_cmd = '0;

        // 1. reset state, then a one-edge reset mid-ramp
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_at_target", int'(at_target), 1);
        check("rst_in_dwell", int'(in_dwell), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        send_cmd(100, 0);
        repeat (3) next_tick();
        check("pre_rst_lft48", int'(lft_spd), 48);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_lft", int'(lft_spd), 0);
        #1 rst_n = 1'b1;

        // 2. ramp up to 100
        send_cmd(100, 0);
        for (int i = 0; i < 7; i++) begin
            next_tick();
            check("ramp_up_lft", int'(lft_spd), up_seq[i]);
            check("ramp_up_at_target", int'(at_target), (i == 6) ? 1 : 0);
            check("ramp_up_rght", int'(rght_spd), 0);
        end

        // 3. down to 40, then reverse to -40 through a dwell
        send_cmd(40, 0);
        repeat (4) next_tick();
        check("down_to_40", int'(lft_spd), 40);
        send_cmd(-40, 0);
        for (int i = 0; i < 8; i++) begin
            next_tick();
            check("reverse_lft", int'(lft_spd), rev_seq[i]);
            if (i < 5) check("reverse_in_dwell", int'(in_dwell), rev_dw[i]);
        end
        check("reverse_at_target", int'(at_target), 1);

        // 4. target changed mid-dwell: dwell still completes
        send_cmd(100, 0);
        next_tick(); check("mid_dwell_a", int'(lft_spd), -24);
        next_tick(); check("mid_dwell_b", int'(lft_spd), -8);
        next_tick(); check("mid_dwell_zero", int'(lft_spd), 0);
        send_cmd(40, 0);
        for (int i = 0; i < 5; i++) begin
            next_tick();
            check("mid_dwell_lft", int'(lft_spd), mid_seq[i]);
            check("mid_dwell_in_dwell", int'(in_dwell), mid_dw[i]);
        end
        // zero target during dwell also lets dwell run out
        send_cmd(-40, 0);
        repeat (3) next_tick();
        check("zero_tgt_enter", int'(in_dwell), 1);
        send_cmd(0, 0);
        next_tick(); check("zero_tgt_dwell", int'(in_dwell), 1);
        next_tick(); check("zero_tgt_done", int'(in_dwell), 0);
        check("zero_tgt_lft", int'(lft_spd), 0);

        // 5. saturation at both rails
        send_cmd(-2048, 0);
        repeat (127) next_tick();
        check("sat_neg_127", int'(lft_spd), -2032);
        next_tick();
        check("sat_neg_128", int'(lft_spd), -2048);
        check("sat_neg_at_target", int'(at_target), 1);
        send_cmd(2047, 0);
        repeat (128) next_tick();
        check("sat_cross_zero", int'(lft_spd), 0);
        check("sat_cross_dwell", int'(in_dwell), 1);
        repeat (2) next_tick();
        check("sat_dwell_done", int'(in_dwell), 0);
        repeat (127) next_tick();
        check("sat_pos_2032", int'(lft_spd), 2032);
        next_tick();
        check("sat_pos_2047", int'(lft_spd), 2047);
        next_tick();
        check("sat_pos_hold", int'(lft_spd), 2047);

        // 6. estop
        pulse_reset();
        send_cmd(96, -48);
        repeat (6) next_tick();
        check("pre_estop_lft", int'(lft_spd), 96);
        check("pre_estop_rght", int'(rght_spd), -48);
        @(posedge clk); #2;
        estop = 1'b1;
`ifdef ESTOP_DECEL_EN
        next_tick();
        check("decel_lft_1", int'(lft_spd), 32);
        check("decel_rght_1", int'(rght_spd), 0);
        next_tick();
        check("decel_lft_2", int'(lft_spd), 0);
`else
        @(posedge clk); #1;
        check("estop_lft", int'(lft_spd), 0);
        check("estop_rght", int'(rght_spd), 0);
`endif
        send_cmd(100, 100);
        @(posedge clk); #2;
        estop = 1'b0;
        repeat (3) next_tick();
        check("post_estop_lft", int'(lft_spd), 0);
        check("post_estop_rght", int'(rght_spd), 0);
        check("post_estop_at_target", int'(at_target), 1);
        send_cmd(50, -50);
        next_tick();
        check("resume_lft", int'(lft_spd), 16);
        check("resume_rght", int'(rght_spd), -16);
        // estop while both channels dwell
        send_cmd(-50, 50);
        next_tick();
        check("estop_dwell_enter", int'(in_dwell), 1);
        @(posedge clk); #2;
        estop = 1'b1;
        repeat (2) @(posedge clk);
        #2 estop = 1'b0;
        next_tick();
        check("estop_dwell_cleared", int'(in_dwell), 0);
        check("estop_dwell_lft", int'(lft_spd), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
